// File: rtl/tx_source_arbiter.sv
// Round-robin arbiter sharing one byte-wide Tx path between NUM_SRC frame sources.
// A source is locked for a whole frame; an optional idle gap is enforced between frames.
module tx_source_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int GAP_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_data_valid,
  input  logic [NUM_SRC*3-1:0] src_data_bits,
  output logic [NUM_SRC-1:0]   src_req,
  output logic [7:0]           out_data,
  output logic                 out_data_valid,
  output logic [2:0]           out_data_bits,
  input  logic                 out_req,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     pick_next;
  logic [2*NUM_SRC-1:0] rotated;

  // Rotate the request vector so bit 0 is the source at rr_q, then take the first hit.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] nxt;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_next  = '0;
    sum        = '0;
    nxt        = '0;
    rotated    = {src_data_valid, src_data_valid} >> rr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!pick_found && rotated[k]) begin
        pick_found = 1'b1;
        sum = {1'b0, rr_q} + SUM_W'(k);
        if (sum >= SUM_W'(NUM_SRC)) sum = sum - SUM_W'(NUM_SRC);
        nxt = sum + SUM_W'(1);
        if (nxt == SUM_W'(NUM_SRC)) nxt = '0;
        pick_idx  = sum[PTR_W-1:0];
        pick_next = nxt[PTR_W-1:0];
      end
    end
  end

  // grant_q is all-zero outside BUSY, so the one-hot OR-mux also yields zeros there.
  always_comb begin
    out_data      = '0;
    out_data_bits = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        out_data      = src_data[8*i +: 8];
        out_data_bits = src_data_bits[3*i +: 3];
      end
    end
  end

  assign out_data_valid = |(grant_q & src_data_valid);
  assign src_req        = grant_q & {NUM_SRC{out_req}};
  assign grant          = grant_q;
  assign busy           = (state_q != ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          grant_d = NUM_SRC'(1) << pick_idx;
          rr_d    = pick_next;
        end
      end
      ST_BUSY: begin
        // The frame ends only when the locked source itself drops valid.
        if (!out_data_valid) begin
          grant_d = '0;
          if (GAP_TICKS > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Bench for tx_source_arbiter: two instances (gap 4 and gap 0) driven from shared inputs,
// checked per cycle against a frame-level reference model plus vector table and directed sequences.
module tb_tx_source_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [8*N-1:0]   src_data;
  logic [N-1:0]     src_data_valid;
  logic [3*N-1:0]   src_data_bits;
  logic             out_req;

  logic [N-1:0] g4_src_req, g4_grant;
  logic [7:0]   g4_out_data;
  logic         g4_out_data_valid;
  logic [2:0]   g4_out_data_bits;
  logic         g4_busy;

  logic [N-1:0] g0_src_req, g0_grant;
  logic [7:0]   g0_out_data;
  logic         g0_out_data_valid;
  logic [2:0]   g0_out_data_bits;
  logic         g0_busy;

  tx_source_arbiter #(.NUM_SRC(N), .GAP_TICKS(4)) dut_g4 (
    .clk(clk), .rst(rst),
    .src_data(src_data), .src_data_valid(src_data_valid), .src_data_bits(src_data_bits),
    .src_req(g4_src_req), .out_data(g4_out_data), .out_data_valid(g4_out_data_valid),
    .out_data_bits(g4_out_data_bits), .out_req(out_req), .grant(g4_grant), .busy(g4_busy)
  );

  tx_source_arbiter #(.NUM_SRC(N), .GAP_TICKS(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .src_data(src_data), .src_data_valid(src_data_valid), .src_data_bits(src_data_bits),
    .src_req(g0_src_req), .out_data(g0_out_data), .out_data_valid(g0_out_data_valid),
    .out_data_bits(g0_out_data_bits), .out_req(out_req), .grant(g0_grant), .busy(g0_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model per instance (0: gap 4, 1: gap 0): owner index or -1, idle ticks still owed,
  // and the index where the next search starts.
  int m_owner[2];
  int m_gap[2];
  int m_ptr[2];
  logic [N-1:0] last_req0;

  function automatic int gap_of(input int g);
    return (g == 0) ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_owner[g] = -1;
      m_gap[g]   = 0;
      m_ptr[g]   = 0;
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_owner[g] = -1;
        m_gap[g]   = 0;
        m_ptr[g]   = 0;
      end else if (m_owner[g] >= 0) begin
        if (!src_data_valid[m_owner[g]]) begin
          m_owner[g] = -1;
          m_gap[g]   = gap_of(g);
        end
      end else if (m_gap[g] > 0) begin
        m_gap[g] = m_gap[g] - 1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr[g] + k) % N;
          if (src_data_valid[i]) begin
            m_owner[g] = i;
            m_ptr[g]   = (i + 1) % N;
            break;
          end
        end
      end
    end
  endtask

  // Called shortly after a falling edge with inputs already driven: compare, advance, next falling edge.
  task automatic cycle();
    logic [N-1:0] eg, er;
    logic [7:0]   ed;
    logic [2:0]   eb;
    logic         ev, ebusy;
    string        p;
    #1;
    for (int g = 0; g < 2; g++) begin
      eg = '0; ed = '0; eb = '0; ev = 1'b0;
      if (m_owner[g] >= 0) begin
        eg[m_owner[g]] = 1'b1;
        ev = src_data_valid[m_owner[g]];
        ed = src_data[8*m_owner[g] +: 8];
        eb = src_data_bits[3*m_owner[g] +: 3];
      end
      er    = out_req ? eg : '0;
      ebusy = (m_owner[g] >= 0) || (m_gap[g] > 0);
      p     = (g == 0) ? "gap4" : "gap0";
      if (g == 0) begin
        last_req0 = er;
        check({p, " grant"},     32'(g4_grant),          32'(eg));
        check({p, " src_req"},   32'(g4_src_req),        32'(er));
        check({p, " out_valid"}, 32'(g4_out_data_valid), 32'(ev));
        check({p, " out_data"},  32'(g4_out_data),       32'(ed));
        check({p, " out_bits"},  32'(g4_out_data_bits),  32'(eb));
        check({p, " busy"},      32'(g4_busy),           32'(ebusy));
      end else begin
        check({p, " grant"},     32'(g0_grant),          32'(eg));
        check({p, " src_req"},   32'(g0_src_req),        32'(er));
        check({p, " out_valid"}, 32'(g0_out_data_valid), 32'(ev));
        check({p, " out_data"},  32'(g0_out_data),       32'(ed));
        check({p, " out_bits"},  32'(g0_out_data_bits),  32'(eb));
        check({p, " busy"},      32'(g0_busy),           32'(ebusy));
      end
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [7:0] d0,
                       input logic [7:0] d1, input logic oreq);
    rst            = r;
    src_data_valid = v;
    src_data       = {d1, d0};
    src_data_bits  = '0;
    out_req        = oreq;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic [7:0] d1;
    logic [2:0] b1;
    logic       oreq;
    logic [1:0] e_grant;
    logic [1:0] e_req;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_bits;
    logic       e_busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int got[4];
    int nfr;
    logic [N-1:0] prev;

    // Single frame from source 1 on the gap-4 instance, including the trailing gap.
    tbl[0]  = '{1'b0, 2'b10, 8'hA5, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'b10, 8'hA5, 3'd0, 1'b1, 2'b10, 2'b10, 1'b1, 8'hA5, 3'd0, 1'b1};
    tbl[2]  = '{1'b0, 2'b10, 8'h3C, 3'd0, 1'b0, 2'b10, 2'b00, 1'b1, 8'h3C, 3'd0, 1'b1};
    tbl[3]  = '{1'b0, 2'b10, 8'h3C, 3'd0, 1'b1, 2'b10, 2'b10, 1'b1, 8'h3C, 3'd0, 1'b1};
    tbl[4]  = '{1'b0, 2'b10, 8'h0F, 3'd4, 1'b0, 2'b10, 2'b00, 1'b1, 8'h0F, 3'd4, 1'b1};
    tbl[5]  = '{1'b0, 2'b10, 8'h0F, 3'd4, 1'b1, 2'b10, 2'b10, 1'b1, 8'h0F, 3'd4, 1'b1};
    tbl[6]  = '{1'b0, 2'b00, 8'h00, 3'd0, 1'b1, 2'b10, 2'b10, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[7]  = '{1'b0, 2'b00, 8'h00, 3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[8]  = '{1'b0, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[10] = '{1'b0, 2'b00, 8'h00, 3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[11] = '{1'b0, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0};

    model_reset();
    last_req0 = '0;
    drive(1'b1, 2'b11, 8'h55, 8'h66, 1'b1);
    @(posedge clk);
    @(negedge clk);

    // Reset with every source requesting.
    #1;
    check("reset grant",     32'(g4_grant),          32'h0);
    check("reset out_valid", 32'(g4_out_data_valid), 32'h0);
    check("reset src_req",   32'(g4_src_req),        32'h0);
    check("reset busy",      32'(g4_busy),           32'h0);
    cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    cycle();

    for (int i = 0; i < 12; i++) begin
      rst            = tbl[i].rst;
      src_data_valid = tbl[i].vld;
      src_data       = {tbl[i].d1, 8'h00};
      src_data_bits  = {tbl[i].b1, 3'd0};
      out_req        = tbl[i].oreq;
      #1;
      check($sformatf("vec%0d grant", i),     32'(g4_grant),          32'(tbl[i].e_grant));
      check($sformatf("vec%0d src_req", i),   32'(g4_src_req),        32'(tbl[i].e_req));
      check($sformatf("vec%0d out_valid", i), 32'(g4_out_data_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d out_data", i),  32'(g4_out_data),       32'(tbl[i].e_data));
      check($sformatf("vec%0d out_bits", i),  32'(g4_out_data_bits),  32'(tbl[i].e_bits));
      check($sformatf("vec%0d busy", i),      32'(g4_busy),           32'(tbl[i].e_busy));
      cycle();
    end

    // Contention: both request with the pointer at 0; source 1 waits out frame + gap.
    drive(1'b0, 2'b11, 8'h11, 8'h22, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, 8'h11, 8'h22, 1'b1);
      #1;
      check("contend grant src0", 32'(g4_grant),   32'h1);
      check("contend src_req",    32'(g4_src_req), 32'h1);
      cycle();
    end
    drive(1'b0, 2'b10, 8'h11, 8'h22, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b10, 8'h11, 8'h22, 1'b1);
      #1;
      check("contend gap grant",   32'(g4_grant),   32'h0);
      check("contend gap busy",    32'(g4_busy),    32'h1);
      check("contend gap src_req", 32'(g4_src_req), 32'h0);
      cycle();
    end
    drive(1'b0, 2'b10, 8'h11, 8'h22, 1'b0);
    #1;
    check("contend idle busy", 32'(g4_busy), 32'h0);
    cycle();
    #1;
    check("contend grant src1", 32'(g4_grant), 32'h2);
    cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    // Round-robin: a source drops valid for one tick after each req, then re-requests.
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    cycle();
    rst  = 1'b0;
    nfr  = 0;
    prev = '0;
    for (int i = 0; i < 4; i++) got[i] = -1;
    for (int c = 0; c < 80 && nfr < 4; c++) begin
      src_data_valid = ~last_req0;
      src_data       = {8'hB1, 8'hB0};
      out_req        = (m_owner[0] >= 0);
      cycle();
      if (g4_grant != '0 && prev == '0) begin
        got[nfr] = g4_grant[1] ? 1 : 0;
        nfr++;
      end
      prev = g4_grant;
    end
    check("rr frames seen", 32'(nfr), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr frame%0d source", i), 32'(got[i]), 32'(i % 2));
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    // Reset in the middle of a source-0 frame.
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    cycle();
    drive(1'b0, 2'b01, 8'h11, 8'h99, 1'b0);
    cycle();
    drive(1'b0, 2'b01, 8'h11, 8'h99, 1'b1);
    #1;
    check("midrst grant before", 32'(g4_grant), 32'h1);
    cycle();
    drive(1'b0, 2'b01, 8'h22, 8'h99, 1'b1);
    cycle();
    drive(1'b1, 2'b10, 8'h33, 8'h99, 1'b0);
    cycle();
    drive(1'b0, 2'b10, 8'h33, 8'h99, 1'b0);
    #1;
    check("midrst grant after",  32'(g4_grant), 32'h0);
    check("midrst busy after",   32'(g4_busy),  32'h0);
    check("midrst gap0 grant",   32'(g0_grant), 32'h0);
    cycle();
    #1;
    check("midrst src1 grant", 32'(g4_grant),          32'h2);
    check("midrst src1 valid", 32'(g4_out_data_valid), 32'h1);
    cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    // Zero-gap instance: one idle tick between back-to-back frames.
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    cycle();
    drive(1'b0, 2'b01, 8'h44, 8'h77, 1'b0);
    cycle();
    drive(1'b0, 2'b01, 8'h44, 8'h77, 1'b1);
    #1;
    check("nogap grant src0", 32'(g0_grant), 32'h1);
    cycle();
    drive(1'b0, 2'b10, 8'h44, 8'h77, 1'b0);
    #1;
    check("nogap still locked", 32'(g0_grant), 32'h1);
    cycle();
    #1;
    check("nogap idle grant", 32'(g0_grant), 32'h0);
    check("nogap idle busy",  32'(g0_busy),  32'h0);
    cycle();
    #1;
    check("nogap grant src1", 32'(g0_grant), 32'h2);
    check("nogap busy src1",  32'(g0_busy),  32'h1);
    cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    // Random traffic with sticky valids so frames span several ticks.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 3) == 0) src_data_valid[s] = ~src_data_valid[s];
      src_data      = 16'($urandom);
      src_data_bits = 6'($urandom);
      out_req       = 1'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
